mux_scan_n: RTL and testbench
=============================

Name: mux_scan_n

Overview:
- Parametrised N-channel, W-bit registered selector. Successor to the fixed 8-channel 8-bit combinational selector.
- Adds an auto-scan mode with a prescaler, a per-channel enable mask that skips disabled channels, hold/freeze, and a channel-change strobe.
- Sits between the display-data sources and the seven-segment/LED scan drivers in the lab framework. It also serves as a generic registered N:1 data selector.

Parameters:
- WIDTH, 8: bit width of each channel.
- CHANNELS, 8: number of input channels (2..16).
- SELW, 3: select/index width; must satisfy 2**SELW >= CHANNELS.
- SCAN_DIV, 4: clock cycles per channel dwell in scan mode (>=1).

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- din, input, CHANNELS*WIDTH: flat channel bus; channel k = din[k*WIDTH +: WIDTH].
- mode, input, 1: 0 = manual select, 1 = auto scan.
- sel, input, SELW: manual channel index (used when mode=0).
- en_mask, input, CHANNELS: bit k=1 means channel k takes part in scan.
- hold, input, 1: freeze all state.
- dout, output, WIDTH: registered selected data.
- ch, output, SELW: registered index of the channel driving dout.
- strobe, output, 1: one-cycle pulse, asserted in the cycle ch takes a new value.

Behaviour:
- Reset: the rising edge with rst_n=0 sets dout=0, ch=0, strobe=0 and prescaler=0. Reset overrides hold and mode. Reset mid-scan restarts from channel 0 with a full dwell.
- Core rule: every non-hold cycle, ch <= ch_next and dout <= channel(ch_next) sampled from din this cycle. Latency from din/sel to dout is 1 cycle. dout tracks live din of the selected channel every cycle, not only at channel change.
- Manual (mode=0):
  - ch_next = sel when sel < CHANNELS.
  - When sel >= CHANNELS: ch_next = ch and dout <= 0.
  - en_mask is ignored; the prescaler is held at 0.
- Scan (mode=1):
  - Prescaler counts 0..SCAN_DIV-1 and wraps to 0.
  - At terminal count, ch_next = first index j in ch+1, ch+2, ... (mod CHANNELS) with en_mask[j]=1.
  - If only the current channel is enabled, ch_next = ch and strobe stays 0.
  - If en_mask is all zero, ch_next = ch and dout <= 0.
  - If the current channel becomes disabled mid-dwell, dout keeps tracking it until terminal count. There is no early skip.
  - Wrap-around: from index CHANNELS-1 the search continues at 0.
- Mode switches:
  - manual to scan: prescaler restarts at 0 and the scan continues from the current ch.
  - scan to manual: takes effect the same cycle; prescaler cleared.
- hold=1: ch, dout and prescaler are frozen and strobe=0. Releasing hold resumes the prescaler from its frozen count.
- strobe is registered: strobe <= (ch_next != ch) && !hold.
- Index arithmetic is SELW bits wide with an explicit modulo-CHANNELS wrap, and must be correct for non-power-of-2 CHANNELS.

Decomposition:
- Shared constants header: mode encodings MODE_MANUAL=0 and MODE_SCAN=1.
- Sub-module scan_prescaler (parameter SCAN_DIV):
  - inputs clk, rst_n, clr, hold.
  - output tc, a one-cycle terminal-count pulse.
- Next-enabled-channel search is combinational in the top module: a priority rotate over en_mask.

Test Plan (WIDTH=8, CHANNELS=8, SCAN_DIV=4, din channel k = 8'h10+k unless stated):
1. Reset: hold rst_n=0 for 2 edges with mode=1 and hold=1 -> dout=8'h00, ch=0, strobe=0. Release -> first advance after exactly 4 cycles.
2. Manual: mode=0, sel=5 -> next edge dout=8'h15, ch=5, strobe=1 for one cycle. Change din ch5 to 8'hAA -> dout=8'hAA one cycle later, strobe=0.
3. Scan with skip: mode=1, en_mask=8'b1010_0101 -> ch sequence 0,2,5,7,0 with a 4-cycle dwell each. strobe pulses once per change; dout matches the channel each time.
4. Mask edge cases:
   - en_mask=8'h00 -> ch frozen, dout=8'h00, no strobe.
   - en_mask=8'h08 while ch=3 -> ch stays 3, no strobe.
5. Hold mid-dwell: assert hold at prescaler=2 for 10 cycles -> ch/dout unchanged, strobe=0. After release, advance occurs 2 cycles later.
6. Illegal select and mode switch: CHANNELS=6 variant, mode=0, sel=7 -> dout=8'h00 and ch unchanged. Then mode=1 from ch=5, en_mask all ones -> advance wraps to ch=0 after 4 cycles.

Source files
------------

// File: rtl/mux_scan_n_pkg.sv
// Shared definitions for the mux_scan_n selector.
//   mode_e : encoding of the mode input (manual select vs. auto scan).
package mux_scan_n_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

endpackage

// File: rtl/mux_scan_n_if.sv
// Bus bundle between a data/control source and the mux_scan_n selector.
//   din     : flat channel bus, channel k = din[k*WIDTH +: WIDTH]
//   mode    : 0 manual select, 1 auto scan
//   sel     : manual channel index
//   en_mask : bit k=1 lets channel k take part in the scan
//   hold    : freeze all selector state
//   dout    : registered selected data
//   ch      : registered index of the channel driving dout
//   strobe  : one-cycle pulse in the cycle ch takes a new value
// Flow control: none. There is no valid/ready pair; every input is sampled
// on each rising clock edge where hold=0, and the outputs are valid from the
// first edge after reset onward.
interface mux_scan_n_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SELW     = 3
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic                      mode;
  logic [SELW-1:0]           sel;
  logic [CHANNELS-1:0]       en_mask;
  logic                      hold;
  logic [WIDTH-1:0]          dout;
  logic [SELW-1:0]           ch;
  logic                      strobe;

  modport master (
    output din, mode, sel, en_mask, hold,
    input  dout, ch, strobe
  );

  modport slave (
    input  din, mode, sel, en_mask, hold,
    output dout, ch, strobe
  );
endinterface

// File: rtl/mux_scan_n_scan_prescaler.sv
// Dwell prescaler for the auto-scan mode.
//   clk, rst_n : clock, synchronous active-low reset (count -> 0)
//   clr        : force the count back to 0 (used while not scanning)
//   hold       : freeze the count; takes priority over clr
//   tc         : one-cycle pulse on the last cycle of each SCAN_DIV-cycle dwell
module scan_prescaler #(
  parameter int SCAN_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic tc
);

  localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Only a cycle that actually lets the count move may end a dwell.
  assign tc = (cnt == LAST) && !hold && !clr;

endmodule

// File: rtl/mux_scan_n.sv
// Registered N:1 channel selector with manual select and auto scan.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mux_scan_n_if slave (din, mode, sel, en_mask, hold in;
//                dout, ch, strobe out)
// Every non-hold edge loads ch with the next channel and dout with that
// channel's live data, so dout follows din with one cycle of latency even
// when the channel does not change.
module mux_scan_n
  import mux_scan_n_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SELW     = 3,
  parameter int SCAN_DIV = 4
) (
  input logic          clk,
  input logic          rst_n,
  mux_scan_n_if.slave  bus
);

  // Channel count in SELW+1 bits so ch+offset never overflows before the wrap.
  localparam logic [SELW:0] NCH = (SELW + 1)'(CHANNELS);

  logic [SELW-1:0]  ch_q, ch_next, nxt;
  logic [WIDTH-1:0] dout_q, dout_next;
  logic             strobe_q;
  logic             scan_mode, sel_ok, found, zero_out, tc;

  assign scan_mode = (bus.mode == MODE_SCAN);
  assign sel_ok    = ({1'b0, bus.sel} < NCH);

  // Prescaler is held at 0 outside scan mode, so entering scan always
  // starts a full dwell on the current channel.
  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!scan_mode),
    .hold  (bus.hold),
    .tc    (tc)
  );

  // Priority rotate over en_mask: look at ch+1, ch+2, ... ch+CHANNELS
  // (mod CHANNELS). Scanning from the far end down lets the closest enabled
  // candidate win. Offset CHANNELS lands back on ch itself, so a mask with
  // only the current channel set yields nxt == ch, and found == 0 exactly
  // when the whole mask is clear.
  always_comb begin
    logic [SELW:0] cand;
    found = 1'b0;
    nxt   = ch_q;
    cand  = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      cand = {1'b0, ch_q} + (SELW + 1)'(i);
      if (cand >= NCH) begin
        cand = cand - NCH;
      end
      if (bus.en_mask[cand[SELW-1:0]]) begin
        found = 1'b1;
        nxt   = cand[SELW-1:0];
      end
    end
  end

  // Next channel and whether dout is forced to zero.
  always_comb begin
    ch_next  = ch_q;
    zero_out = 1'b0;
    if (!scan_mode) begin
      if (sel_ok) begin
        ch_next = bus.sel;
      end else begin
        zero_out = 1'b1;
      end
    end else if (!found) begin
      zero_out = 1'b1;
    end else if (tc) begin
      ch_next = nxt;
    end
  end

  // Data mux on the channel that will be current after this edge.
  always_comb begin
    dout_next = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!zero_out && ch_next == SELW'(k)) begin
        dout_next = bus.din[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_q     <= '0;
      dout_q   <= '0;
      strobe_q <= 1'b0;
    end else if (bus.hold) begin
      strobe_q <= 1'b0;
    end else begin
      ch_q     <= ch_next;
      dout_q   <= dout_next;
      strobe_q <= (ch_next != ch_q);
    end
  end

  assign bus.dout   = dout_q;
  assign bus.ch     = ch_q;
  assign bus.strobe = strobe_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: an 8-channel and a 6-channel instance share one
// stimulus stream; a behavioural model is compared on every falling edge,
// and directed sequences pin literal expectations.
module tb_mux_scan_n;

  localparam int SD = 4;

  // ---------------- clock / reset / stimulus state ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [2:0] sel;
  logic [7:0] en_mask;
  logic       hold;
  logic [7:0] dv [8];
  logic [63:0] din8;
  logic [47:0] din6;

  initial forever #5 clk = ~clk;

  always_comb begin
    din8 = '0;
    din6 = '0;
    for (int k = 0; k < 8; k++) din8[k*8 +: 8] = dv[k];
    for (int k = 0; k < 6; k++) din6[k*8 +: 8] = dv[k];
  end

  mux_scan_n_if #(.WIDTH(8), .CHANNELS(8), .SELW(3)) b8 ();
  mux_scan_n_if #(.WIDTH(8), .CHANNELS(6), .SELW(3)) b6 ();

  assign b8.din = din8;  assign b8.mode = mode;  assign b8.sel = sel;
  assign b8.en_mask = en_mask;  assign b8.hold = hold;
  assign b6.din = din6;  assign b6.mode = mode;  assign b6.sel = sel;
  assign b6.en_mask = en_mask[5:0];  assign b6.hold = hold;

  mux_scan_n #(.WIDTH(8), .CHANNELS(8), .SELW(3), .SCAN_DIV(SD)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8));
  mux_scan_n #(.WIDTH(8), .CHANNELS(6), .SELW(3), .SCAN_DIV(SD)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(b6));

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_cnt counts cycles spent in the current dwell (0..SD-1).
  int m_ch [2];
  int m_cnt [2];
  int m_dout [2];
  int m_st [2];

  task automatic model_step(input int k, input int n);
    int  nch, nd, mk, j;
    bit  term, got;
    if (!rst_n) begin
      m_ch[k] = 0; m_dout[k] = 0; m_st[k] = 0; m_cnt[k] = 0;
    end else if (hold) begin
      m_st[k] = 0;
    end else begin
      nch = m_ch[k];
      nd  = 0;
      mk  = int'(en_mask) & ((1 << n) - 1);
      if (!mode) begin
        m_cnt[k] = 0;
        if (int'(sel) < n) begin
          nch = int'(sel);
          nd  = int'(dv[nch]);
        end
      end else begin
        term = (m_cnt[k] == SD - 1);
        m_cnt[k] = term ? 0 : m_cnt[k] + 1;
        if (mk != 0) begin
          if (term) begin
            got = 1'b0;
            for (int i = 1; i <= n; i++) begin
              j = (m_ch[k] + i) % n;
              if (!got && ((mk >> j) & 1) == 1) begin
                nch = j;
                got = 1'b1;
              end
            end
          end
          nd = int'(dv[nch]);
        end
      end
      m_st[k]   = (nch != m_ch[k]) ? 1 : 0;
      m_ch[k]   = nch;
      m_dout[k] = nd;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 8);
    model_step(1, 6);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m8_dout",   32'(b8.dout),   32'(m_dout[0]));
      chk("m8_ch",     32'(b8.ch),     32'(m_ch[0]));
      chk("m8_strobe", 32'(b8.strobe), 32'(m_st[0]));
      chk("m6_dout",   32'(b6.dout),   32'(m_dout[1]));
      chk("m6_ch",     32'(b6.ch),     32'(m_ch[1]));
      chk("m6_strobe", 32'(b6.strobe), 32'(m_st[1]));
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  // ---------------- directed + random sequences ----------------
  initial begin
    logic [2:0] seq [4];
    seq[0] = 3'd2; seq[1] = 3'd5; seq[2] = 3'd7; seq[3] = 3'd0;

    rst_n = 1'b0; mode = 1'b1; hold = 1'b1; sel = 3'd0; en_mask = 8'hFF;
    for (int k = 0; k < 8; k++) dv[k] = 8'h10 + 8'(k);

    // Reset overrides hold and mode.
    steps(2);
    chk_en = 1'b1;
    chk("rst_dout", 32'(b8.dout), 32'h00);
    chk("rst_ch", 32'(b8.ch), 32'd0);
    chk("rst_strobe", 32'(b8.strobe), 32'd0);

    // First advance lands exactly on the 4th edge after release.
    rst_n = 1'b1; hold = 1'b0;
    steps(3);
    chk("rel_ch_wait", 32'(b8.ch), 32'd0);
    step();
    chk("rel_ch_adv", 32'(b8.ch), 32'd1);
    chk("rel_strobe", 32'(b8.strobe), 32'd1);

    // Manual select and live tracking.
    mode = 1'b0; sel = 3'd5;
    step();
    chk("man_dout", 32'(b8.dout), 32'h15);
    chk("man_ch", 32'(b8.ch), 32'd5);
    chk("man_strobe", 32'(b8.strobe), 32'd1);
    dv[5] = 8'hAA;
    step();
    chk("man_track", 32'(b8.dout), 32'hAA);
    chk("man_strobe0", 32'(b8.strobe), 32'd0);
    dv[5] = 8'h15;

    // Scan with skipped channels: 0 -> 2 -> 5 -> 7 -> 0.
    sel = 3'd0;
    step();
    mode = 1'b1; en_mask = 8'b1010_0101;
    for (int s = 0; s < 4; s++) begin
      steps(3);
      chk("scan_dwell", 32'(b8.strobe), 32'd0);
      step();
      chk("scan_ch", 32'(b8.ch), 32'(seq[s]));
      chk("scan_dout", 32'(b8.dout), 32'h10 + 32'(seq[s]));
      chk("scan_strobe", 32'(b8.strobe), 32'd1);
    end

    // Empty mask: channel frozen, output zero.
    en_mask = 8'h00;
    steps(8);
    chk("mask0_ch", 32'(b8.ch), 32'd0);
    chk("mask0_dout", 32'(b8.dout), 32'h00);
    chk("mask0_strobe", 32'(b8.strobe), 32'd0);

    // Only the current channel enabled: stays put.
    mode = 1'b0; sel = 3'd3;
    step();
    mode = 1'b1; en_mask = 8'h08;
    steps(8);
    chk("self_ch", 32'(b8.ch), 32'd3);
    chk("self_strobe", 32'(b8.strobe), 32'd0);
    chk("self_dout", 32'(b8.dout), 32'h13);

    // Hold in the middle of a dwell (count at 2).
    en_mask = 8'hFF;
    steps(2);
    hold = 1'b1;
    steps(10);
    chk("hold_ch", 32'(b8.ch), 32'd3);
    chk("hold_dout", 32'(b8.dout), 32'h13);
    chk("hold_strobe", 32'(b8.strobe), 32'd0);
    hold = 1'b0;
    step();
    chk("hold_rel1", 32'(b8.ch), 32'd3);
    step();
    chk("hold_rel2", 32'(b8.ch), 32'd4);
    chk("hold_rel2_st", 32'(b8.strobe), 32'd1);

    // Out-of-range select on the 6-channel instance, then wrap in scan.
    mode = 1'b0; sel = 3'd5;
    step();
    sel = 3'd7;
    step();
    chk("ill_dout6", 32'(b6.dout), 32'h00);
    chk("ill_ch6", 32'(b6.ch), 32'd5);
    chk("ill_ch8", 32'(b8.ch), 32'd7);
    mode = 1'b1; en_mask = 8'hFF;
    steps(3);
    chk("wrap6_wait", 32'(b6.ch), 32'd5);
    step();
    chk("wrap6_ch", 32'(b6.ch), 32'd0);
    chk("wrap6_dout", 32'(b6.dout), 32'h10);
    chk("wrap8_ch", 32'(b8.ch), 32'd0);

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      hold  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0:       en_mask = 8'h00;
          1:       en_mask = 8'(1 << $urandom_range(0, 7));
          default: en_mask = 8'($urandom_range(0, 255));
        endcase
      end
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0) dv[k] = 8'($urandom_range(0, 255));
      end
      step();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
